// File: rtl/jtag_pkg.sv
// Shared TAP definitions: state encoding, IR capture pattern, IDCODE length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jtag_pkg;

  // IEEE 1149.1 state codes; the values match the usual TAP encoding so
  // tap_state can be read directly on a logic analyser.
  typedef enum logic [3:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  localparam logic [1:0] IR_CAPTURE_PAT = 2'b01;
  localparam int         IDCODE_LEN     = 32;

endpackage

// File: rtl/jtag_tap_core_if.sv
// JTAG pin and user-register bundle between a JTAG host and the TAP core.
// Latency: n/a (wires only).
// Backpressure: none; JTAG is paced purely by tck.
// master: drives tms/tdi/user_tdo, observes everything else.
// slave : the TAP core; consumes tms/tdi/user_tdo, drives tdo, state, IR and strobes.
interface jtag_tap_core_if #(
  parameter int IR_WIDTH = 5,
  parameter int NUM_USER = 2
);
  import jtag_pkg::*;

  logic                tms;
  logic                tdi;
  logic                tdo;
  logic                tdo_en;
  tap_state_t          tap_state;
  logic [IR_WIDTH-1:0] ir_out;
  logic                tl_reset;
  logic [NUM_USER-1:0] user_sel;
  logic                capture_dr;
  logic                shift_dr;
  logic                update_dr;
  logic [NUM_USER-1:0] user_tdo;

  modport master (
    output tms, tdi, user_tdo,
    input  tdo, tdo_en, tap_state, ir_out, tl_reset, user_sel,
           capture_dr, shift_dr, update_dr
  );

  modport slave (
    input  tms, tdi, user_tdo,
    output tdo, tdo_en, tap_state, ir_out, tl_reset, user_sel,
           capture_dr, shift_dr, update_dr
  );

endinterface

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller: state register plus next-state logic.
// Latency: state advances on every posedge tck according to tms.
// Backpressure: none. Ports: tck, trst (async, active-high), tms in; tap_state out.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst,
  input  logic       tms,
  output tap_state_t tap_state
);

  tap_state_t state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = tms ? TLR    : RTI;
      RTI:      state_d = tms ? SEL_DR : RTI;
      SEL_DR:   state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = tms ? EX1_DR : SHIFT_DR;
      SHIFT_DR: state_d = tms ? EX1_DR : SHIFT_DR;
      EX1_DR:   state_d = tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = tms ? UPD_DR : SHIFT_DR;
      UPD_DR:   state_d = tms ? SEL_DR : RTI;
      SEL_IR:   state_d = tms ? TLR    : CAP_IR;
      CAP_IR:   state_d = tms ? EX1_IR : SHIFT_IR;
      SHIFT_IR: state_d = tms ? EX1_IR : SHIFT_IR;
      EX1_IR:   state_d = tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = tms ? UPD_IR : SHIFT_IR;
      UPD_IR:   state_d = tms ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) state_q <= TLR;
    else      state_q <= state_d;
  end

  assign tap_state = state_q;

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP: FSM, instruction register, BYPASS/IDCODE DRs, user DR decode, TDO mux.
// Latency: capture/shift on posedge leaving Cap/Shift; tdo registered on negedge; BYPASS = 1 tck.
// Backpressure: none. Ports: tck, trst plain; everything else via jtag_tap_core_if.slave.
module jtag_tap_core
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH     = 5,
  parameter logic [31:0]         IDCODE_VAL   = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_OP    = IR_WIDTH'(5'h01),
  parameter int                  NUM_USER     = 2,
  parameter logic [IR_WIDTH-1:0] USER_OP_BASE = IR_WIDTH'(5'h10)
) (
  input  logic           tck,
  input  logic           trst,
  jtag_tap_core_if.slave bus
);

  tap_state_t state;

  logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0]   ir_out_q, ir_out_d;
  logic                  bypass_q, bypass_d;
  logic [IDCODE_LEN-1:0] idcode_q, idcode_d;
  logic                  tdo_q, tdo_d;
  logic                  tdo_en_q, tdo_en_d;

  logic                  sel_idcode;
  logic                  sel_bypass;
  logic [NUM_USER-1:0]   user_sel;
  logic                  any_user;

  jtag_tap_fsm u_fsm (
    .tck       (tck),
    .trst      (trst),
    .tms       (bus.tms),
    .tap_state (state)
  );

  // Instruction decode. IDCODE wins if its opcode ever aliases a user slot;
  // anything unrecognised falls back to BYPASS.
  always_comb begin
    sel_idcode = (ir_out_q == IDCODE_OP);
    user_sel   = '0;
    for (int i = 0; i < NUM_USER; i++) begin
      if (!sel_idcode && (ir_out_q == USER_OP_BASE + IR_WIDTH'(i))) user_sel[i] = 1'b1;
    end
    any_user   = |user_sel;
    sel_bypass = !sel_idcode && !any_user;
  end

  // Posedge data path: IR and built-in DR capture/shift.
  always_comb begin
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    idcode_d   = idcode_q;
    case (state)
      CAP_IR: begin
        ir_shift_d      = '0;
        ir_shift_d[1:0] = IR_CAPTURE_PAT;
      end
      SHIFT_IR: ir_shift_d = {bus.tdi, ir_shift_q[IR_WIDTH-1:1]};
      CAP_DR: begin
        if (sel_bypass) bypass_d = 1'b0;
        if (sel_idcode) idcode_d = IDCODE_VAL;
      end
      SHIFT_DR: begin
        if (sel_bypass) bypass_d = bus.tdi;
        if (sel_idcode) idcode_d = {bus.tdi, idcode_q[IDCODE_LEN-1:1]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
      idcode_q   <= IDCODE_VAL;
    end else begin
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
      idcode_q   <= idcode_d;
    end
  end

  // Negedge path: active IR and the serial output. Sampling the shift
  // registers half a cycle after the posedge keeps tdo stable across the
  // next posedge, where the downstream device samples it.
  always_comb begin
    ir_out_d = ir_out_q;
    if (state == UPD_IR) ir_out_d = ir_shift_q;
    if (state == TLR)    ir_out_d = IDCODE_OP;

    tdo_d    = 1'b0;
    tdo_en_d = (state == SHIFT_IR) || (state == SHIFT_DR);
    if (state == SHIFT_IR) begin
      tdo_d = ir_shift_q[0];
    end else if (state == SHIFT_DR) begin
      if (sel_idcode)      tdo_d = idcode_q[0];
      else if (sel_bypass) tdo_d = bypass_q;
      else                 tdo_d = |(user_sel & bus.user_tdo);
    end
  end

  always_ff @(negedge tck or posedge trst) begin
    if (trst) begin
      ir_out_q <= IDCODE_OP;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      ir_out_q <= ir_out_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign bus.tdo        = tdo_q;
  assign bus.tdo_en     = tdo_en_q;
  assign bus.tap_state  = state;
  assign bus.ir_out     = ir_out_q;
  assign bus.tl_reset   = (state == TLR);
  assign bus.user_sel   = user_sel;
  // Strobes only concern user registers; built-in DRs run silently.
  assign bus.capture_dr = (state == CAP_DR)   && any_user;
  assign bus.shift_dr   = (state == SHIFT_DR) && any_user;
  assign bus.update_dr  = (state == UPD_DR)   && any_user;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Testbench for jtag_tap_core: drives tms/tdi between edges and scoreboards tdo.
// Latency: expected tdo bits queued at stimulus, popped after each negedge.
// Backpressure: n/a.
module tb_jtag_tap_core;
  import jtag_pkg::*;

  localparam int          IRW = 5;
  localparam int          NU  = 2;
  localparam logic [31:0] IDV = 32'h1000_0001;

  logic tck = 1'b0;
  logic trst;

  jtag_tap_core_if #(.IR_WIDTH(IRW), .NUM_USER(NU)) bus ();

  jtag_tap_core #(
    .IR_WIDTH     (IRW),
    .IDCODE_VAL   (IDV),
    .IDCODE_OP    (5'h01),
    .NUM_USER     (NU),
    .USER_OP_BASE (5'h10)
  ) dut (
    .tck  (tck),
    .trst (trst),
    .bus  (bus)
  );

  always #5 tck = ~tck;

  int n_chk = 0;
  int n_err = 0;
  bit exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // One tck: inputs applied just after a negedge, outputs observed just after the next negedge.
  task automatic step(input bit t, input bit d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
  endtask

  task automatic push_bits(input int n, input logic [63:0] v);
    for (int k = 0; k < n; k++) exp_q.push_back(v[k]);
  endtask

  task automatic pop_chk(input string tag);
    bit e;
    if (exp_q.size() == 0) begin
      chk({tag, "_underflow"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(bus.tdo), 32'(e));
    end
  endtask

  // Called while in a Shift state: compare tdo then shift one bit, n times.
  task automatic scan(input string tag, input int n, input logic [63:0] din, input bit exit_last);
    for (int k = 0; k < n; k++) begin
      pop_chk(tag);
      step(exit_last && (k == n - 1), din[k]);
    end
  endtask

  // From RTI: load an instruction and return to RTI.
  task automatic load_ir(input logic [IRW-1:0] v);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("ir_tdo_en", 32'(bus.tdo_en), 32'd1);
    push_bits(IRW, 64'(IR_CAPTURE_PAT));
    scan("ir_capture", IRW, 64'(v), 1'b1);
    step(1'b1, 1'b0);
    chk("ir_update", 32'(bus.ir_out), 32'(v));
    step(1'b0, 1'b0);
  endtask

  task automatic rti_to_shdr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  tap_state_t  p_st  [16] = '{TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EX1_DR, PAUSE_DR, EX2_DR,
                              UPD_DR, SEL_IR, CAP_IR, SHIFT_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR};
  int          p_len [16] = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
  logic [7:0]  p_bits[16] = '{8'b111, 8'b0, 8'b1, 8'b01, 8'b001, 8'b101, 8'b0101, 8'b10101,
                              8'b1101, 8'b11, 8'b011, 8'b0011, 8'b1011, 8'b01011, 8'b101011, 8'b11011};
  logic [1:0]  u_pat [4]  = '{2'b10, 2'b01, 2'b01, 2'b10};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.tms      = 1'b1;
    bus.tdi      = 1'b0;
    bus.user_tdo = '0;
    trst         = 1'b0;
    #1 trst = 1'b1;
    #2;
    chk("rst_state",    32'(bus.tap_state), 32'(TLR));
    chk("rst_ir",       32'(bus.ir_out), 32'h01);
    chk("rst_tdo",      32'(bus.tdo), 32'd0);
    chk("rst_tdo_en",   32'(bus.tdo_en), 32'd0);
    chk("rst_tl_reset", 32'(bus.tl_reset), 32'd1);
    chk("rst_user_sel", 32'(bus.user_sel), 32'd0);
    chk("rst_strobes",  32'({bus.capture_dr, bus.shift_dr, bus.update_dr}), 32'd0);
    @(negedge tck);
    #2 trst = 1'b0;

    // IDCODE read with a pause in the middle
    step(1'b0, 1'b0);
    chk("rti_state", 32'(bus.tap_state), 32'(RTI));
    chk("rti_tl_reset", 32'(bus.tl_reset), 32'd0);
    rti_to_shdr();
    chk("id_tdo_en", 32'(bus.tdo_en), 32'd1);
    chk("id_no_strobe", 32'(bus.shift_dr), 32'd0);
    push_bits(32, 64'(IDV));
    push_bits(4, 64'd0);
    scan("idcode", 12, 64'd0, 1'b1);
    step(1'b0, 1'b0);
    chk("pause_tdo", 32'(bus.tdo), 32'd0);
    chk("pause_tdo_en", 32'(bus.tdo_en), 32'd0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    scan("idcode", 24, 64'd0, 1'b1);
    chk("idcode_drained", 32'(exp_q.size()), 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // All-ones instruction selects BYPASS
    load_ir(5'h1F);
    chk("byp_user_sel", 32'(bus.user_sel), 32'd0);
    rti_to_shdr();
    chk("byp_no_strobe", 32'(bus.shift_dr), 32'd0);
    push_bits(4, 64'b1010);
    scan("bypass", 4, 64'b1101, 1'b1);
    step(1'b1, 1'b0);
    chk("byp_no_update", 32'(bus.update_dr), 32'd0);
    step(1'b0, 1'b0);

    // User register 1
    load_ir(5'h11);
    chk("u1_sel", 32'(bus.user_sel), 32'd2);
    step(1'b1, 1'b0);
    chk("u1_seldr_cap", 32'(bus.capture_dr), 32'd0);
    step(1'b0, 1'b0);
    chk("u1_capture", 32'(bus.capture_dr), 32'd1);
    chk("u1_cap_shift", 32'(bus.shift_dr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus.user_tdo = u_pat[k];
      exp_q.push_back(u_pat[k][1]);
      step(1'b0, 1'b0);
      chk("u1_shift", 32'(bus.shift_dr), 32'd1);
      pop_chk("u1_tdo");
    end
    step(1'b1, 1'b0);
    chk("u1_ex1_shift", 32'(bus.shift_dr), 32'd0);
    step(1'b1, 1'b0);
    chk("u1_update", 32'(bus.update_dr), 32'd1);
    step(1'b0, 1'b0);
    chk("u1_rti_update", 32'(bus.update_dr), 32'd0);

    // Opcode just past the last user slot falls back to BYPASS
    load_ir(5'h12);
    chk("u2_sel", 32'(bus.user_sel), 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("u2_capture", 32'(bus.capture_dr), 32'd0);
    bus.user_tdo = 2'b11;
    step(1'b0, 1'b0);
    chk("u2_shift", 32'(bus.shift_dr), 32'd0);
    exp_q.push_back(1'b0);
    pop_chk("u2_tdo");
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("u2_update", 32'(bus.update_dr), 32'd0);
    step(1'b0, 1'b0);
    bus.user_tdo = '0;

    // Asynchronous reset in the middle of a user DR shift
    load_ir(5'h11);
    rti_to_shdr();
    chk("mid_sel", 32'(bus.user_sel), 32'd2);
    bus.tms = 1'b1;
    #1 trst = 1'b1;
    #1;
    chk("mid_state",   32'(bus.tap_state), 32'(TLR));
    chk("mid_ir",      32'(bus.ir_out), 32'h01);
    chk("mid_tdo",     32'(bus.tdo), 32'd0);
    chk("mid_tdo_en",  32'(bus.tdo_en), 32'd0);
    chk("mid_user",    32'(bus.user_sel), 32'd0);
    chk("mid_strobes", 32'({bus.capture_dr, bus.shift_dr, bus.update_dr}), 32'd0);
    #1 trst = 1'b0;
    @(negedge tck);
    #1;
    chk("mid_post_state", 32'(bus.tap_state), 32'(TLR));
    step(1'b0, 1'b0);
    rti_to_shdr();
    push_bits(8, 64'(IDV));
    scan("mid_idcode", 8, 64'd0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Five ones reach TLR from every state, and TLR restores IDCODE
    for (int s = 0; s < 16; s++) begin
      load_ir(5'h1F);
      for (int k = 0; k < p_len[s]; k++) step(p_bits[s][k], 1'b0);
      chk("path_state", 32'(bus.tap_state), 32'(p_st[s]));
      for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
      chk("tlr_state", 32'(bus.tap_state), 32'(TLR));
      chk("tlr_ir", 32'(bus.ir_out), 32'h01);
      step(1'b0, 1'b0);
    end

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/jtag_tap_core.md
# jtag_tap_core

Parametrised JTAG test access port. It combines the 16-state TAP state machine with:
- a configurable-width instruction register;
- built-in BYPASS and IDCODE data registers;
- decode and strobes for N user data registers;
- a registered TDO mux.

It sits between the chip-level JTAG pins and the debug/scan blocks. It replaces the bare state-decode controller by owning the IR, the instruction decode and the serial output path.

## Interface
Parameters:
- IR_WIDTH, 5, instruction register width (≥2)
- IDCODE_VAL, 32'h1000_0001, value captured into the IDCODE DR (bit 0 must be 1)
- IDCODE_OP, 5'h01, IDCODE opcode; also the IR reset value
- NUM_USER, 2, number of user data registers (1..8)
- USER_OP_BASE, 5'h10, user register i is selected when IR == USER_OP_BASE + i

Ports:
- tck  in  1  test clock; all logic on this clock, both edges
- trst  in  1  reset, asynchronous, active-high
- tms  in  1  mode select, sampled on posedge tck
- tdi  in  1  serial data in, sampled on posedge tck
- tdo  out  1  serial data out, changes on negedge tck
- tdo_en  out  1  high while shifting IR or DR
- tap_state  out  4  current state (jtag_pkg::tap_state_t)
- ir_out  out  IR_WIDTH  active (updated) instruction
- tl_reset  out  1  high while in Test-Logic-Reset
- user_sel  out  NUM_USER  one-hot user DR select, decoded from ir_out
- capture_dr, shift_dr, update_dr  out  1 each  DR phase strobes, qualified by any user_sel bit
- user_tdo  in  NUM_USER  serial outputs of the user registers

## Operation
- **States and transitions**: IEEE 1149.1 16-state FSM with standard TMS transitions. Encoding comes from jtag_pkg: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
- **Five-ones rule**: five consecutive posedges with tms=1 reach TLR from any state.
- **IR shift register**:
  - CapIR: load {0…0, 2'b01}.
  - ShIR: shift right, tdi enters the MSB, the LSB feeds tdo.
- **Active IR (ir_out)**:
  - loads from the shift register on negedge tck in UpdIR;
  - loads IDCODE_OP on negedge tck in TLR;
  - never changes elsewhere.
- **Instruction decode**:
  - IDCODE_OP selects the IDCODE DR;
  - USER_OP_BASE+i with i<NUM_USER selects user i;
  - every other value, including all-ones, selects BYPASS.
- **BYPASS DR**: 1 bit. CapDR loads 0; ShDR loads tdi.
- **IDCODE DR**: 32 bits. CapDR loads IDCODE_VAL; ShDR shifts right with tdi into bit 31.
- **TDO mux**:
  - ShIR: IR shift register LSB;
  - ShDR: LSB of the selected DR, or user_tdo[i] when user i is selected;
  - otherwise tdo holds 0.
- **Strobes**: capture_dr, shift_dr and update_dr are combinational decodes of tap_state == CapDR/ShDR/UpdDR, ANDed with |user_sel. Built-in DRs do not assert them.

## Timing
- **trst asserted (asynchronous)**: state=TLR, ir_out=IDCODE_OP, IR shift register=0, BYPASS=0, IDCODE DR=IDCODE_VAL, tdo=0, tdo_en=0.
- **Values while trst is held** (follow from the reset values above): tl_reset=1, user_sel=0, all strobes=0.
- **trst deasserted**: takes effect immediately. The first posedge after deassertion samples tms normally.
- **State**: updates on posedge tck.
- **Shift registers**: capture/shift happen on the posedge that leaves CapXX/ShXX, i.e. action in state S, registered at the end of S.
- **tdo and tdo_en**: registered on negedge tck from the current state. tdo is valid half a cycle after entering ShXX and stays stable across the following posedge.
- **Latency**: the first bit out is the captured LSB. BYPASS adds exactly one tck of delay from tdi to tdo.
- **Pause states**: PauseIR/PauseDR hold all shift contents. Ex2 returns to Shift without a recapture.
- **trst mid-shift**: shift contents are lost and ir_out reverts to IDCODE_OP. No update strobe is emitted.
- **Instruction change mid-DR-scan**: impossible, because ir_out changes only in UpdIR or TLR.

## Structure
- **jtag_pkg**: tap_state_t enum (codes above) and the constants IR_CAPTURE_PAT=2'b01 and IDCODE_LEN=32.
- **Sub-module jtag_tap_fsm** (tck, trst, tms → tap_state): state register plus next-state logic only.
- **jtag_tap_core** holds IR, DRs, decode and the TDO mux.

## Test plan
- **Reset**: assert trst mid-ShDR → tap_state=F, ir_out=5'h01, tdo=0, tdo_en=0 with no tck edge.
- **TLR from anywhere**: from each of the 16 states apply tms=1 ×5 → tap_state=F; ir_out=IDCODE_OP after the next negedge.
- **IDCODE read**: TLR→RTI→SelDR→CapDR→ShDR, shift 32 bits with tdi=0 → tdo sequence LSB-first equals 32'h1000_0001, followed by zeros.
- **IR capture/update**: shift IR with tdi pattern 5'b11111 → first 5 tdo bits are 1,0,0,0,0; after UpdIR, ir_out=5'h1F and BYPASS is selected.
- **Bypass**: ir=1F, shift DR with tdi=1,0,1,1 → tdo=0,1,0,1. Captured 0, one-cycle delay.
- **User DR**: load ir=5'h11 → user_sel=2'b10. In ShDR, tdo follows user_tdo[1]. capture_dr, shift_dr and update_dr each pulse in their states. With ir=5'h12, user_sel=0 and no strobes.
